// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined RV32I control unit: opcodes, control encodings, ID/EX bundle.
// PIPE_CTRL_ILLEGAL_TRAP_EN adds an illegal bit to the ID/EX bundle.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resultsrc_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } aluctrl_t;

    typedef struct packed {
        logic       regwrite;
        resultsrc_t resultsrc;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alusrc_a;
        logic       alusrc_b;
        aluctrl_t   alucontrol;
        logic [2:0] funct3;
`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_e_t;

    // Shared R/I arithmetic decode; only register ops may turn funct7b5 into a subtract.
    function automatic aluctrl_t alu_arith(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Decode-side inputs, hazard controls and per-stage control outputs of pipe_ctrl_unit.
// master = core datapath/hazard unit, slave = the control unit.
interface pipe_ctrl_unit_if;

    logic [6:0] op_d;
    logic [2:0] funct3_d;
    logic       funct7b5_d;
    logic       stall_e;
    logic       flush_e;
    logic       zero_e;
    logic       lt_e;
    logic       ltu_e;

    logic [2:0] immsrc_d;
    logic       illegal_d;
    logic [3:0] alucontrol_e;
    logic       alusrc_a_e;
    logic       alusrc_b_e;
    logic       pcsrc_e;
    logic       jalr_e;
    logic       resultsrc_e0;
    logic       regwrite_m;
    logic       memwrite_m;
    logic [1:0] resultsrc_m;
    logic       regwrite_w;
    logic [1:0] resultsrc_w;

    modport master (
        output op_d, funct3_d, funct7b5_d, stall_e, flush_e, zero_e, lt_e, ltu_e,
        input  immsrc_d, illegal_d, alucontrol_e, alusrc_a_e, alusrc_b_e, pcsrc_e,
               jalr_e, resultsrc_e0, regwrite_m, memwrite_m, resultsrc_m,
               regwrite_w, resultsrc_w
    );

    modport slave (
        input  op_d, funct3_d, funct7b5_d, stall_e, flush_e, zero_e, lt_e, ltu_e,
        output immsrc_d, illegal_d, alucontrol_e, alusrc_a_e, alusrc_b_e, pcsrc_e,
               jalr_e, resultsrc_e0, regwrite_m, memwrite_m, resultsrc_m,
               regwrite_w, resultsrc_w
    );

endinterface

// File: rtl/pipe_ctrl_dec.sv
// Combinational main + ALU decode for RV32I in the Decode stage.
// PIPE_CTRL_ILLEGAL_TRAP_EN enables illegal detection and forces illegal instructions to a NOP.
module pipe_ctrl_dec
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_U    = 1,
    parameter int unsigned SUPPORT_JALR = 1
) (
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output ctrl_e_t    ctrl,
    output immsrc_t    immsrc,
    output logic       illegal
);

    ctrl_e_t raw;
    logic    known;

    always_comb begin
        raw        = '0;
        raw.funct3 = funct3;
        immsrc     = IMM_I;
        known      = 1'b1;
        case (op)
            OP_LOAD: begin
                raw.regwrite  = 1'b1;
                raw.resultsrc = RES_MEM;
                raw.alusrc_b  = 1'b1;
            end
            OP_STORE: begin
                raw.memwrite = 1'b1;
                raw.alusrc_b = 1'b1;
                immsrc       = IMM_S;
            end
            OP_R: begin
                raw.regwrite   = 1'b1;
                raw.alucontrol = alu_arith(funct3, funct7b5, 1'b1);
            end
            OP_I: begin
                raw.regwrite   = 1'b1;
                raw.alusrc_b   = 1'b1;
                raw.alucontrol = alu_arith(funct3, funct7b5, 1'b0);
            end
            OP_B: begin
                raw.branch     = 1'b1;
                raw.alucontrol = ALU_SUB;
                immsrc         = IMM_B;
            end
            OP_JAL: begin
                raw.regwrite  = 1'b1;
                raw.resultsrc = RES_PC4;
                raw.jump      = 1'b1;
                immsrc        = IMM_J;
            end
            OP_JALR: begin
                if (SUPPORT_JALR != 0) begin
                    raw.regwrite  = 1'b1;
                    raw.resultsrc = RES_PC4;
                    raw.jump      = 1'b1;
                    raw.jalr      = 1'b1;
                    raw.alusrc_b  = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
            OP_LUI: begin
                if (SUPPORT_U != 0) begin
                    raw.regwrite  = 1'b1;
                    raw.resultsrc = RES_IMM;
                    immsrc        = IMM_U;
                end else begin
                    known = 1'b0;
                end
            end
            OP_AUIPC: begin
                if (SUPPORT_U != 0) begin
                    raw.regwrite = 1'b1;
                    raw.alusrc_a = 1'b1;
                    raw.alusrc_b = 1'b1;
                    immsrc       = IMM_U;
                end else begin
                    known = 1'b0;
                end
            end
            default: known = 1'b0;
        endcase
    end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    logic r_bad;
    logic illegal_w;

    // Only instr[30] is visible, so flag it where no RV32I R-op defines funct7 = 0100000.
    assign r_bad     = (op == OP_R) && funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101);
    assign illegal_w = ~known | r_bad;

    always_comb begin
        ctrl = raw;
        if (illegal_w) ctrl = '0;
        ctrl.illegal = illegal_w;
    end

    assign illegal = illegal_w;
`else
    always_comb begin
        ctrl = raw;
        if (!known) ctrl = '0;
    end

    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: decode, ID/EX/MEM/WB control registers, Execute branch resolve.
// PIPE_CTRL_ILLEGAL_TRAP_EN carries an illegal bit through ID/EX (see pipe_ctrl_pkg).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_U    = 1,
    parameter int unsigned SUPPORT_JALR = 1,
    parameter int unsigned FULL_BRANCH  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_ctrl_unit_if.slave cif
);

    ctrl_e_t    ctrl_d;
    ctrl_e_t    ctrl_e;
    immsrc_t    immsrc_dec;
    logic       illegal_dec;
    logic       taken;

    logic       regwrite_mq;
    logic       memwrite_mq;
    resultsrc_t resultsrc_mq;
    logic       regwrite_wq;
    resultsrc_t resultsrc_wq;

    pipe_ctrl_dec #(
        .SUPPORT_U    (SUPPORT_U),
        .SUPPORT_JALR (SUPPORT_JALR)
    ) u_dec (
        .op       (cif.op_d),
        .funct3   (cif.funct3_d),
        .funct7b5 (cif.funct7b5_d),
        .ctrl     (ctrl_d),
        .immsrc   (immsrc_dec),
        .illegal  (illegal_dec)
    );

    // Flush outranks stall so a squashed slot cannot be held alive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_e <= '0;
        end else if (cif.flush_e) begin
            ctrl_e <= '0;
        end else if (!cif.stall_e) begin
            ctrl_e <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_mq  <= 1'b0;
            memwrite_mq  <= 1'b0;
            resultsrc_mq <= RES_ALU;
            regwrite_wq  <= 1'b0;
            resultsrc_wq <= RES_ALU;
        end else begin
            regwrite_mq  <= ctrl_e.regwrite;
            memwrite_mq  <= ctrl_e.memwrite;
            resultsrc_mq <= ctrl_e.resultsrc;
            regwrite_wq  <= regwrite_mq;
            resultsrc_wq <= resultsrc_mq;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (ctrl_e.funct3)
            3'b000:  taken = cif.zero_e;
            3'b001:  taken = ~cif.zero_e;
            3'b100:  taken = (FULL_BRANCH != 0) &&  cif.lt_e;
            3'b101:  taken = (FULL_BRANCH != 0) && !cif.lt_e;
            3'b110:  taken = (FULL_BRANCH != 0) &&  cif.ltu_e;
            3'b111:  taken = (FULL_BRANCH != 0) && !cif.ltu_e;
            default: taken = 1'b0;
        endcase
    end

    assign cif.immsrc_d     = immsrc_dec;
    assign cif.illegal_d    = illegal_dec;
    assign cif.alucontrol_e = ctrl_e.alucontrol;
    assign cif.alusrc_a_e   = ctrl_e.alusrc_a;
    assign cif.alusrc_b_e   = ctrl_e.alusrc_b;
    assign cif.pcsrc_e      = ctrl_e.jump | (ctrl_e.branch & taken);
    assign cif.jalr_e       = ctrl_e.jalr;
    assign cif.resultsrc_e0 = ctrl_e.resultsrc[0];
    assign cif.regwrite_m   = regwrite_mq;
    assign cif.memwrite_m   = memwrite_mq;
    assign cif.resultsrc_m  = resultsrc_mq;
    assign cif.regwrite_w   = regwrite_wq;
    assign cif.resultsrc_w  = resultsrc_wq;

endmodule
